// File: rtl/cordic_divider_pipe.sv
// Pipelined unsigned fixed-point divider built from non-restoring linear-CORDIC
// iterations, one register stage per iteration plus a final correction stage.
module cordic_divider_pipe #(
  parameter int unsigned DATA_WIDTH = 12,
  parameter int unsigned INT_BITS   = 2,
  parameter int unsigned FRAC_BITS  = 10,
  parameter int unsigned TAG_WIDTH  = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [DATA_WIDTH-1:0]           a_i,
  input  logic [DATA_WIDTH-1:0]           b_i,
  input  logic [TAG_WIDTH-1:0]            tag_i,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [INT_BITS+FRAC_BITS-1:0]   q_o,
  output logic [DATA_WIDTH-1:0]           rem_o,
  output logic [TAG_WIDTH-1:0]            tag_o,
  output logic                            ovf_o,
  output logic                            dz_o
);

  localparam int unsigned STAGES = INT_BITS + FRAC_BITS;
  localparam int unsigned RW     = DATA_WIDTH + STAGES + 1;
  localparam int unsigned ZW     = STAGES + 1;
  localparam int unsigned LAST   = STAGES - 1;

  logic adv;
  logic out_valid_q;

  // Whole pipe moves together whenever the output slot is free or being drained.
  assign adv      = !out_valid_q || out_ready;
  assign in_ready = adv || rst;

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    localparam int unsigned SH = STAGES - 1 - i;

    logic signed [RW-1:0]   r_in, r_d, r_q;
    logic signed [ZW-1:0]   z_in, z_d, z_q;
    logic signed [RW-1:0]   bsh;
    logic [DATA_WIDTH-1:0]  b_in, b_q;
    logic [TAG_WIDTH-1:0]   tag_in, tag_q;
    logic                   v_in, v_q;
    logic                   ovf_in, ovf_q;
    logic                   dz_in, dz_q;

    if (i == 0) begin : g_first
      assign r_in   = RW'(a_i) << FRAC_BITS;
      assign z_in   = '0;
      assign b_in   = b_i;
      assign tag_in = tag_i;
      assign v_in   = in_valid;
      assign dz_in  = (b_i == '0);
      assign ovf_in = (b_i != '0) && (RW'(a_i) >= (RW'(b_i) << INT_BITS));
    end else begin : g_next
      assign r_in   = g_stage[i-1].r_q;
      assign z_in   = g_stage[i-1].z_q;
      assign b_in   = g_stage[i-1].b_q;
      assign tag_in = g_stage[i-1].tag_q;
      assign v_in   = g_stage[i-1].v_q;
      assign dz_in  = g_stage[i-1].dz_q;
      assign ovf_in = g_stage[i-1].ovf_q;
    end

    // Non-restoring step: residual sign picks subtract/add of the shifted divisor.
    assign bsh = RW'(b_in) << SH;
    assign r_d = r_in[RW-1] ? (r_in + bsh) : (r_in - bsh);
    assign z_d = r_in[RW-1] ? (z_in - (ZW'(1) << SH)) : (z_in + (ZW'(1) << SH));

    always_ff @(posedge clk) begin
      if (rst) begin
        r_q   <= '0;
        z_q   <= '0;
        b_q   <= '0;
        tag_q <= '0;
        v_q   <= 1'b0;
        ovf_q <= 1'b0;
        dz_q  <= 1'b0;
      end else if (adv) begin
        r_q   <= r_d;
        z_q   <= z_d;
        b_q   <= b_in;
        tag_q <= tag_in;
        v_q   <= v_in;
        ovf_q <= ovf_in;
        dz_q  <= dz_in;
      end
    end
  end

  logic [STAGES-1:0]     q_d, q_q;
  logic [DATA_WIDTH-1:0] rem_d, rem_q;
  logic [TAG_WIDTH-1:0]  tag_q;
  logic                  ovf_q, dz_q;
  logic signed [RW-1:0]  r_last;
  logic signed [ZW-1:0]  z_last;
  logic [DATA_WIDTH-1:0] b_last;

  assign r_last = g_stage[LAST].r_q;
  assign z_last = g_stage[LAST].z_q;
  assign b_last = g_stage[LAST].b_q;

  // Final correction; flagged operations report saturated quotient and zero remainder.
  always_comb begin
    q_d   = '0;
    rem_d = '0;
    if (g_stage[LAST].dz_q || g_stage[LAST].ovf_q) begin
      q_d   = '1;
      rem_d = '0;
    end else if (r_last[RW-1]) begin
      q_d   = STAGES'(z_last - ZW'(1));
      rem_d = DATA_WIDTH'(r_last + RW'(b_last));
    end else begin
      q_d   = STAGES'(z_last);
      rem_d = DATA_WIDTH'(r_last);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      q_q         <= '0;
      rem_q       <= '0;
      tag_q       <= '0;
      ovf_q       <= 1'b0;
      dz_q        <= 1'b0;
    end else if (adv) begin
      out_valid_q <= g_stage[LAST].v_q;
      q_q         <= q_d;
      rem_q       <= rem_d;
      tag_q       <= g_stage[LAST].tag_q;
      ovf_q       <= g_stage[LAST].ovf_q && !g_stage[LAST].dz_q;
      dz_q        <= g_stage[LAST].dz_q;
    end
  end

  assign out_valid = out_valid_q;
  assign q_o       = q_q;
  assign rem_o     = rem_q;
  assign tag_o     = tag_q;
  assign ovf_o     = ovf_q;
  assign dz_o      = dz_q;

endmodule
